// File: rtl/vend_pkg.sv
// Shared types for the vending engine: FSM states, coin codes, status codes and coin values.
// Pure declarations; no logic, no latency, no flow control.
package vend_pkg;

  typedef enum logic [2:0] {IDLE, CHECK, COLLECT, VEND, REFUND, RESTOCK} state_e;

  typedef enum logic [1:0] {COIN_NONE, COIN_NICKEL, COIN_DIME, COIN_QUARTER} coin_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_AVAIL    = 3'd1,
    ST_SOLD_OUT = 3'd2,
    ST_INSUFF   = 3'd3,
    ST_ERROR    = 3'd4
  } status_e;

  localparam logic [4:0] NICKEL_VAL  = 5'd5;
  localparam logic [4:0] DIME_VAL    = 5'd10;
  localparam logic [4:0] QUARTER_VAL = 5'd25;

  function automatic logic [4:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_NICKEL:  return NICKEL_VAL;
      COIN_DIME:    return DIME_VAL;
      COIN_QUARTER: return QUARTER_VAL;
      default:      return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_if.sv
// Customer, supplier and result signals of the vending engine; master drives, slave is the engine.
// Plain wires; supplier beats are held off by sup_rdy, everything else is unthrottled.
interface vend_if #(
  parameter int N_ITEMS   = 8,
  parameter int MAX_STOCK = 15,
  parameter int COST_W    = 8,
  parameter int BAL_W     = 16
);
  localparam int IDW   = $clog2(N_ITEMS);
  localparam int CNT_W = $clog2(MAX_STOCK + 1);

  logic [1:0]        coin;
  logic              sel_vld;
  logic [IDW-1:0]    sel_id;
  logic              buy;
  logic              cancel;
  logic              sup_vld;
  logic [IDW-1:0]    sup_item;
  logic [CNT_W-1:0]  sup_count;
  logic [COST_W-1:0] sup_cost;
  logic              sup_rdy;
  logic              product_vld;
  logic [IDW-1:0]    product_id;
  logic              change_vld;
  logic [BAL_W-1:0]  change;
  logic [BAL_W-1:0]  credit;
  logic [COST_W-1:0] price_info;
  logic [2:0]        status;

  modport master (
    output coin, sel_vld, sel_id, buy, cancel, sup_vld, sup_item, sup_count, sup_cost,
    input  sup_rdy, product_vld, product_id, change_vld, change, credit, price_info, status
  );

  modport slave (
    input  coin, sel_vld, sel_id, buy, cancel, sup_vld, sup_item, sup_count, sup_cost,
    output sup_rdy, product_vld, product_id, change_vld, change, credit, price_info, status
  );

endinterface

// File: rtl/vend_timer.sv
// Idle down-counter: reloads to TIMEOUT-1, counts down when enabled, flags timeout while at zero.
// Load/decrement take effect on the next edge; no flow control.
module vend_timer #(
  parameter int TIMEOUT = 512
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic timeout
);
  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] RELOAD = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      count <= RELOAD;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign timeout = (count == '0);

endmodule

// File: rtl/vend_engine.sv
// Vending controller: per-slot stock/price tables, coin credit, dispense/refund pulses, restock port.
// sel->status two edges, buy->product pulse next cycle; supplier beats accepted only while sup_rdy.
module vend_engine
  import vend_pkg::*;
#(
  parameter int N_ITEMS   = 8,
  parameter int MAX_STOCK = 15,
  parameter int COST_W    = 8,
  parameter int BAL_W     = 16,
  parameter int TIMEOUT   = 512
) (
  input logic   clk,
  input logic   hrst_n,
  input logic   srst_n,
  vend_if.slave bus
);
  localparam int IDW   = $clog2(N_ITEMS);
  localparam int CNT_W = $clog2(MAX_STOCK + 1);
  localparam logic [CNT_W:0] STOCK_CAP = (CNT_W + 1)'(MAX_STOCK);

  state_e            state;
  status_e           status;
  logic [IDW-1:0]    item;
  logic [CNT_W-1:0]  stock [N_ITEMS];
  logic [COST_W-1:0] cost  [N_ITEMS];
  logic [BAL_W-1:0]  credit;
  logic [COST_W-1:0] price_info;
  logic              product_vld;
  logic [IDW-1:0]    product_id;
  logic              change_vld;
  logic [BAL_W-1:0]  change;
  logic              sup_rdy;

  logic [BAL_W:0]    credit_add;
  logic [BAL_W-1:0]  credit_sum;
  logic [BAL_W-1:0]  price_ext;
  logic [CNT_W:0]    stock_add;
  logic              coin_in;
  logic              sel_ok;
  logic              sup_item_ok;
  logic              tmr_expired;

  assign coin_in     = (state == COLLECT) && (bus.coin != COIN_NONE);
  assign sel_ok      = int'(bus.sel_id) < N_ITEMS;
  assign sup_item_ok = int'(bus.sup_item) < N_ITEMS;

  always_comb begin
    credit_add = {1'b0, credit} + (BAL_W + 1)'(coin_value(bus.coin));
    credit_sum = credit_add[BAL_W] ? '1 : credit_add[BAL_W-1:0];
    price_ext  = '0;
    price_ext[COST_W-1:0] = price_info;
    stock_add  = {1'b0, stock[bus.sup_item]} + {1'b0, bus.sup_count};
  end

  // Held at reload outside COLLECT so entry always starts a full idle window.
  vend_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (hrst_n),
    .load    ((state != COLLECT) || coin_in || !srst_n),
    .dec     (state == COLLECT),
    .timeout (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (!hrst_n) begin
      state       <= IDLE;
      status      <= ST_IDLE;
      item        <= '0;
      credit      <= '0;
      price_info  <= '0;
      product_vld <= 1'b0;
      product_id  <= '0;
      change_vld  <= 1'b0;
      change      <= '0;
      sup_rdy     <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) begin
        stock[i] <= '0;
        cost[i]  <= '0;
      end
    end else if (!srst_n) begin
      product_vld <= 1'b0;
      sup_rdy     <= 1'b0;
      // A refund already on the outputs is allowed to finish rather than repeat.
      if (credit != '0 && state != REFUND) begin
        state      <= REFUND;
        change_vld <= 1'b1;
        change     <= credit;
      end else begin
        state      <= IDLE;
        change_vld <= 1'b0;
        credit     <= '0;
      end
    end else begin
      product_vld <= 1'b0;
      change_vld  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.sup_vld) begin
            state   <= RESTOCK;
            sup_rdy <= 1'b1;
          end else if (bus.sel_vld) begin
            if (sel_ok) begin
              item  <= bus.sel_id;
              state <= CHECK;
            end else begin
              status <= ST_ERROR;
            end
          end
        end
        CHECK: begin
          if (stock[item] == '0) begin
            status <= ST_SOLD_OUT;
            state  <= IDLE;
          end else if (cost[item] == '0) begin
            status <= ST_ERROR;
            state  <= IDLE;
          end else begin
            status     <= ST_AVAIL;
            price_info <= cost[item];
            state      <= COLLECT;
          end
        end
        COLLECT: begin
          credit <= credit_sum;
          if (bus.cancel || tmr_expired) begin
            state      <= REFUND;
            change_vld <= (credit_sum != '0);
            change     <= credit_sum;
          end else if (bus.buy) begin
            if (credit_sum >= price_ext) begin
              state       <= VEND;
              product_vld <= 1'b1;
              product_id  <= item;
              change_vld  <= (credit_sum != price_ext);
              change      <= credit_sum - price_ext;
            end else begin
              status <= ST_INSUFF;
            end
          end
        end
        VEND: begin
          stock[item] <= stock[item] - CNT_W'(1);
          credit      <= '0;
          state       <= IDLE;
        end
        REFUND: begin
          credit <= '0;
          state  <= IDLE;
        end
        RESTOCK: begin
          if (bus.sup_vld) begin
            if (!sup_item_ok || stock_add > STOCK_CAP) begin
              status <= ST_ERROR;
            end else begin
              stock[bus.sup_item] <= stock_add[CNT_W-1:0];
            end
            if (sup_item_ok && bus.sup_cost != '0) begin
              cost[bus.sup_item] <= bus.sup_cost;
            end
          end else begin
            state   <= IDLE;
            sup_rdy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sup_rdy     = sup_rdy;
  assign bus.product_vld = product_vld;
  assign bus.product_id  = product_id;
  assign bus.change_vld  = change_vld;
  assign bus.change      = change;
  assign bus.credit      = credit;
  assign bus.price_info  = price_info;
  assign bus.status      = status;

endmodule

// File: tb/tb_vend_engine.sv
// Directed bench for vend_engine: a transaction-level vending model is compared every cycle,
// plus literal expectations for the worked scenarios and a 9-slot build for the id-range edge.
module tb_vend_engine;

  localparam int TMO = 16;

  logic clk;
  logic hrst_n;
  logic srst_n;

  vend_if #(.N_ITEMS(8), .MAX_STOCK(15), .COST_W(8), .BAL_W(16)) vif ();
  vend_if #(.N_ITEMS(9), .MAX_STOCK(15), .COST_W(8), .BAL_W(16)) vif9 ();

  vend_engine #(.N_ITEMS(8), .MAX_STOCK(15), .COST_W(8), .BAL_W(16), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .hrst_n(hrst_n), .srst_n(srst_n), .bus(vif)
  );

  vend_engine #(.N_ITEMS(9), .MAX_STOCK(15), .COST_W(8), .BAL_W(16), .TIMEOUT(TMO)) u_dut9 (
    .clk(clk), .hrst_n(hrst_n), .srst_n(srst_n), .bus(vif9)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: machine described by activity flags, a count-up quiet-cycle counter and plain int tables.
  int  m_stock [8];
  int  m_cost  [8];
  int  m_credit, m_item, m_quiet;
  bit  m_on, m_checking, m_session, m_vending, m_refunding, m_restocking;
  int  e_status, e_price, e_pid, e_change;
  bit  e_pv, e_cv, e_rdy;

  function automatic int coin_cents(logic [1:0] c);
    case (c)
      2'd1:    return 5;
      2'd2:    return 10;
      2'd3:    return 25;
      default: return 0;
    endcase
  endfunction

  task automatic model_clear_activity();
    m_checking = 0; m_session = 0; m_vending = 0; m_refunding = 0; m_restocking = 0;
  endtask

  task automatic model_start_refund();
    m_refunding = 1;
    e_cv        = (m_credit != 0);
    e_change    = m_credit;
  endtask

  task automatic model_step();
    int  cents;
    int  slot;
    bit  expired;
    if (!hrst_n) begin
      m_on = 1;
      for (int i = 0; i < 8; i++) begin m_stock[i] = 0; m_cost[i] = 0; end
      model_clear_activity();
      m_credit = 0; m_quiet = 0; m_item = 0;
      e_status = 0; e_price = 0; e_pid = 0; e_change = 0; e_pv = 0; e_cv = 0; e_rdy = 0;
      return;
    end
    e_pv = 0;
    e_cv = 0;
    if (!srst_n) begin
      e_rdy = 0;
      if (!m_refunding && m_credit != 0) begin
        model_clear_activity();
        model_start_refund();
      end else begin
        model_clear_activity();
        m_credit = 0;
      end
    end else if (m_vending) begin
      m_stock[m_item] -= 1;
      m_credit  = 0;
      m_vending = 0;
    end else if (m_refunding) begin
      m_credit    = 0;
      m_refunding = 0;
    end else if (m_restocking) begin
      if (vif.sup_vld) begin
        slot = int'(vif.sup_item);
        if (m_stock[slot] + int'(vif.sup_count) > 15) e_status = 4;
        else m_stock[slot] += int'(vif.sup_count);
        if (vif.sup_cost != 0) m_cost[slot] = int'(vif.sup_cost);
      end else begin
        m_restocking = 0;
        e_rdy        = 0;
      end
    end else if (m_checking) begin
      m_checking = 0;
      if (m_stock[m_item] == 0) e_status = 2;
      else if (m_cost[m_item] == 0) e_status = 4;
      else begin
        e_status  = 1;
        e_price   = m_cost[m_item];
        m_session = 1;
        m_quiet   = 0;
      end
    end else if (m_session) begin
      cents    = coin_cents(vif.coin);
      expired  = (m_quiet == TMO - 1);
      m_credit = (m_credit + cents > 65535) ? 65535 : m_credit + cents;
      m_quiet  = (cents != 0) ? 0 : m_quiet + 1;
      if (vif.cancel || expired) begin
        m_session = 0;
        model_start_refund();
      end else if (vif.buy) begin
        if (m_credit >= e_price) begin
          m_session = 0;
          m_vending = 1;
          e_pv      = 1;
          e_pid     = m_item;
          e_cv      = (m_credit != e_price);
          e_change  = m_credit - e_price;
        end else begin
          e_status = 3;
        end
      end
    end else begin
      if (vif.sup_vld) begin
        m_restocking = 1;
        e_rdy        = 1;
      end else if (vif.sel_vld) begin
        if (int'(vif.sel_id) < 8) begin
          m_checking = 1;
          m_item     = int'(vif.sel_id);
        end else begin
          e_status = 4;
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (m_on) begin
      chk("status", vif.status, e_status);
      chk("price_info", vif.price_info, e_price);
      chk("credit", vif.credit, m_credit);
      chk("sup_rdy", vif.sup_rdy, e_rdy);
      chk("product_vld", vif.product_vld, e_pv);
      chk("change_vld", vif.change_vld, e_cv);
      if (e_pv) chk("product_id", vif.product_id, e_pid);
      if (e_cv) chk("change", vif.change, e_change);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic restock(int id, int cnt, int price);
    vif.sup_vld   = 1'b1;
    vif.sup_item  = 3'(id);
    vif.sup_count = 4'(cnt);
    vif.sup_cost  = 8'(price);
    tick();
    for (int k = 0; k < 4 && !vif.sup_rdy; k++) tick();
    chk("sup_rdy_wait", vif.sup_rdy, 1);
    tick();
    vif.sup_vld = 1'b0;
    tick();
  endtask

  task automatic select(int id);
    vif.sel_vld = 1'b1;
    vif.sel_id  = 3'(id);
    tick();
    vif.sel_vld = 1'b0;
    tick();
  endtask

  task automatic insert(logic [1:0] c);
    vif.coin = c;
    tick();
    vif.coin = 2'd0;
  endtask

  task automatic check_tables(string tag);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_stock%0d", tag, i), u_dut.stock[i], m_stock[i]);
      chk($sformatf("%s_cost%0d", tag, i), u_dut.cost[i], m_cost[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    hrst_n = 1'b0; srst_n = 1'b1;
    vif.coin = 0; vif.sel_vld = 0; vif.sel_id = 0; vif.buy = 0; vif.cancel = 0;
    vif.sup_vld = 0; vif.sup_item = 0; vif.sup_count = 0; vif.sup_cost = 0;
    vif9.coin = 0; vif9.sel_vld = 0; vif9.sel_id = 0; vif9.buy = 0; vif9.cancel = 0;
    vif9.sup_vld = 0; vif9.sup_item = 0; vif9.sup_count = 0; vif9.sup_cost = 0;
    tick(3);
    hrst_n = 1'b1;
    chk("rst_status", vif.status, 0);
    chk("rst_credit", vif.credit, 0);
    chk("rst_sup_rdy", vif.sup_rdy, 0);
    chk("rst_price", vif.price_info, 0);
    tick();

    // Restock, buy with three quarters against 65 cents.
    restock(3, 5, 65);
    select(3);
    chk("sel3_status", vif.status, 1);
    chk("sel3_price", vif.price_info, 65);
    insert(2'd3); insert(2'd3); insert(2'd3);
    chk("qqq_credit", vif.credit, 75);
    vif.buy = 1'b1; tick(); vif.buy = 1'b0;
    chk("vend_pv", vif.product_vld, 1);
    chk("vend_pid", vif.product_id, 3);
    chk("vend_change", vif.change, 10);
    tick();
    chk("vend_credit_clear", vif.credit, 0);
    chk("vend_stock3", u_dut.stock[3], 4);

    // Insufficient credit, then cancel.
    select(3);
    insert(2'd2);
    vif.buy = 1'b1; tick(); vif.buy = 1'b0;
    chk("insuff_status", vif.status, 3);
    vif.cancel = 1'b1; tick(); vif.cancel = 1'b0;
    chk("cancel_cv", vif.change_vld, 1);
    chk("cancel_change", vif.change, 10);
    tick();
    chk("cancel_credit", vif.credit, 0);
    chk("cancel_state", u_dut.state, vend_pkg::IDLE);

    // Idle timeout after a nickel: the 16th coin-less cycle refunds.
    select(3);
    insert(2'd1);
    tick(15);
    chk("tmo_not_yet", vif.change_vld, 0);
    tick();
    chk("tmo_cv", vif.change_vld, 1);
    chk("tmo_change", vif.change, 5);
    tick();

    // A coin on the 15th idle cycle restarts the window.
    select(3);
    insert(2'd1);
    tick(14);
    insert(2'd1);
    tick(15);
    chk("reload_state", u_dut.state, vend_pkg::COLLECT);
    chk("reload_credit", vif.credit, 10);
    vif.cancel = 1'b1; tick(); vif.cancel = 1'b0;
    chk("reload_refund", vif.change, 10);
    tick();

    // Overfill rejected while price still updates; exact fill to the ceiling accepted.
    restock(2, 12, 40);
    restock(2, 4, 30);
    chk("overfill_status", vif.status, 4);
    chk("overfill_stock2", u_dut.stock[2], 12);
    chk("overfill_cost2", u_dut.cost[2], 30);
    restock(2, 3, 0);
    chk("fill15_stock2", u_dut.stock[2], 15);
    chk("fill15_cost2", u_dut.cost[2], 30);

    // Supplier beats beat a same-cycle selection.
    vif.sup_vld = 1'b1; vif.sup_item = 3'd5; vif.sup_count = 4'd0; vif.sup_cost = 8'd0;
    vif.sel_vld = 1'b1; vif.sel_id = 3'd3;
    tick();
    vif.sel_vld = 1'b0;
    chk("prio_rdy", vif.sup_rdy, 1);
    chk("prio_state", u_dut.state, vend_pkg::RESTOCK);
    tick();
    vif.sup_vld = 1'b0;
    tick();

    select(6);
    chk("empty_status", vif.status, 2);
    restock(6, 2, 0);
    select(6);
    chk("unpriced_status", vif.status, 4);
    check_tables("mid");

    // Nine-slot build: id 8 is a real slot, id 9 is out of range.
    vif9.sel_vld = 1'b1; vif9.sel_id = 4'd8;
    tick();
    vif9.sel_vld = 1'b0;
    chk("n9_id8_state", u_dut9.state, vend_pkg::CHECK);
    tick();
    chk("n9_id8_status", vif9.status, 2);
    vif9.sel_vld = 1'b1; vif9.sel_id = 4'd9;
    tick();
    vif9.sel_vld = 1'b0;
    chk("n9_id9_status", vif9.status, 4);
    chk("n9_id9_state", u_dut9.state, vend_pkg::IDLE);

    // Soft reset aborts a session with money in it.
    select(3);
    insert(2'd3);
    srst_n = 1'b0; tick(); srst_n = 1'b1;
    chk("srst_cv", vif.change_vld, 1);
    chk("srst_change", vif.change, 25);
    tick();
    chk("srst_credit", vif.credit, 0);
    chk("srst_stock3", u_dut.stock[3], 4);
    chk("srst_cost3", u_dut.cost[3], 65);
    check_tables("srst");

    // Hard reset during the dispense cycle.
    select(3);
    insert(2'd3); insert(2'd3); insert(2'd3);
    vif.buy = 1'b1; tick(); vif.buy = 1'b0;
    chk("hvend_pv_before", vif.product_vld, 1);
    hrst_n = 1'b0; tick(); hrst_n = 1'b1;
    chk("hrst_pv", vif.product_vld, 0);
    chk("hrst_credit", vif.credit, 0);
    chk("hrst_stock3", u_dut.stock[3], 0);
    chk("hrst_cost3", u_dut.cost[3], 0);
    chk("hrst_pid", vif.product_id, 0);
    chk("hrst_change", vif.change, 0);
    tick();

    // Credit saturates at the top of the balance width.
    restock(1, 1, 255);
    select(1);
    repeat (2630) insert(2'd3);
    chk("sat_credit", vif.credit, 65535);
    vif.cancel = 1'b1; tick(); vif.cancel = 1'b0;
    chk("sat_change", vif.change, 65535);
    tick();

    // Exact payment completed by a coin in the buy cycle: no change pulse.
    restock(4, 2, 50);
    select(4);
    insert(2'd3);
    vif.coin = 2'd3; vif.buy = 1'b1; tick(); vif.coin = 2'd0; vif.buy = 1'b0;
    chk("exact_pv", vif.product_vld, 1);
    chk("exact_pid", vif.product_id, 4);
    chk("exact_cv", vif.change_vld, 0);
    chk("exact_credit", vif.credit, 50);
    tick();
    chk("exact_stock4", u_dut.stock[4], 1);
    check_tables("end");

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
